// File: rtl/md_iter_core.sv
// md_iter_core
// Iterative multiply/divide core with a valid/ready request port and a
// valid/ready result port.
//   - Multiply: full 64-bit product, signed or unsigned. The result appears
//     MUL_LAT cycles after the request is accepted.
//   - Divide: 32-step restoring division on operand magnitudes, followed by
//     one sign/special-case fix-up cycle (33 cycles total).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1.
//   - Request side: ready is in_ready (IDLE only). A request is taken only if
//     in_op is 1 or 2; in_op 0 and 3 are ignored.
//   - Result side: valid is out_valid (DONE only). The results are held until
//     out_ready is seen, for any number of cycles.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   in_src0 / in_src1    multiplicand/dividend, multiplier/divisor
//   in_op, in_sign       1 = mul, 2 = div; in_sign = 1 selects signed operands
//   in_valid / in_ready  request handshake
//   out_res0 / out_res1  LO (product low or quotient), HI (product high or remainder)
//   out_valid / out_ready result handshake
//   o_dbg_state          current FSM state encoding
module md_iter_core #(
    parameter int MUL_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_src0,
    input  logic [31:0] in_src1,
    input  logic [1:0]  in_op,
    input  logic        in_sign,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_res0,
    output logic [31:0] out_res1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [4:0] MUL_LOAD = 5'(MUL_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sign;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_res0;
    logic [31:0] r_res1;

    logic        w_accept;
    logic        w_is_mul;
    logic        w_is_div;
    logic [31:0] w_in_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_fix_q;
    logic [31:0] w_fix_r;

    assign w_is_mul = (in_op == 2'd1);
    assign w_is_div = (in_op == 2'd2);
    assign w_accept = (r_state == IDLE) && in_valid && (w_is_mul || w_is_div);

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign out_res0    = r_res0;
    assign out_res1    = r_res1;
    assign o_dbg_state = r_state;

    // Dividend magnitude is taken straight from the request so the
    // quotient shift register can be loaded on the accept edge.
    assign w_in_a_mag = (in_sign && in_src0[31]) ? (32'd0 - in_src0) : in_src0;
    assign w_b_mag    = (r_sign && r_b[31]) ? (32'd0 - r_b) : r_b;

    // Extending both operands to 64 bits (sign or zero) lets one 64-bit
    // multiplier produce either the signed or the unsigned product.
    assign w_ext_a = r_sign ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_ext_b = r_sign ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract if the divisor fits. The partial remainder is
    // always below 2*divisor, so bit 32 of the difference is its sign.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, w_b_mag};
    assign w_ge     = ~w_diff[32];

    always_comb begin
        w_fix_q = r_quo;
        w_fix_r = r_rem;
        if (r_b == 32'd0) begin
            w_fix_q = 32'hFFFF_FFFF;
            w_fix_r = r_a;
        end else if (r_sign && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF)) begin
            w_fix_q = 32'h8000_0000;
            w_fix_r = 32'd0;
        end else begin
            if (r_sign && (r_a[31] ^ r_b[31])) w_fix_q = 32'd0 - r_quo;
            // Remainder follows the dividend sign; negating zero keeps it zero.
            if (r_sign && r_a[31])             w_fix_r = 32'd0 - r_rem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_is_mul ? MUL : DIV;
            MUL:  if (r_cnt == 5'd0) w_next = DONE;
            DIV:  if (r_cnt == 5'd0) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= 5'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_sign <= 1'b0;
            r_quo  <= 32'd0;
            r_rem  <= 32'd0;
            r_res0 <= 32'd0;
            r_res1 <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a    <= in_src0;
                        r_b    <= in_src1;
                        r_sign <= in_sign;
                        r_quo  <= w_in_a_mag;
                        r_rem  <= 32'd0;
                        r_cnt  <= w_is_mul ? MUL_LOAD : 5'd31;
                    end
                end
                MUL: begin
                    if (r_cnt == 5'd0) begin
                        r_res0 <= w_prod[31:0];
                        r_res1 <= w_prod[63:32];
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                DIV: begin
                    r_quo <= {r_quo[30:0], w_ge};
                    r_rem <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
                    if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
                end
                FIX: begin
                    r_res0 <= w_fix_q;
                    r_res1 <= w_fix_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_iter_core.sv
module tb_md_iter_core;
  logic        clk;
  logic        reset;
  logic [31:0] in_src0;
  logic [31:0] in_src1;
  logic [1:0]  in_op;
  logic        in_sign;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_res0;
  logic [31:0] out_res1;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  md_iter_core #(.MUL_LAT(5)) dut (
    .clk(clk), .reset(reset),
    .in_src0(in_src0), .in_src1(in_src1), .in_op(in_op), .in_sign(in_sign),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_res0(out_res0), .out_res1(out_res1),
    .out_valid(out_valid), .out_ready(out_ready),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: present a request, scramble inputs after acceptance, wait for result
  task automatic run_op(input logic [1:0] op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output logic ready_seen);
    in_src0 = a; in_src1 = b; in_op = op; in_sign = sgn; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_src0 = 32'hDEAD_BEEF; in_src1 = 32'h0; in_op = 2'd3; in_sign = ~sgn;
    lat = -1;
    ready_seen = in_ready;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
      if (in_ready) ready_seen = 1'b1;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_src0 = '0; in_src1 = '0; in_op = '0; in_sign = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_res0 !== 32'd0) begin errors++; $display("FAIL reset_res0: got %h expected 0", out_res0); end
    checks++; if (out_res1 !== 32'd0) begin errors++; $display("FAIL reset_res1: got %h expected 0", out_res1); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    int lat; logic rs;
    run_op(2'd1, 1'b1, 32'hFFFF_FFFF, 32'h2, lat, rs);
    checks++; if (lat !== 5) begin errors++; $display("FAIL smul_latency: got %0d expected 5", lat); end
    checks++; if (out_res0 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL smul_res0: got %h expected fffffffe", out_res0); end
    checks++; if (out_res1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL smul_res1: got %h expected ffffffff", out_res1); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL smul_in_ready_busy: got %b expected 0", rs); end
    consume();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL smul_consume: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
    run_op(2'd1, 1'b0, 32'hFFFF_FFFF, 32'h2, lat, rs);
    checks++; if (out_res0 !== 32'hFFFF_FFFE) begin errors++; $display("FAIL umul_res0: got %h expected fffffffe", out_res0); end
    checks++; if (out_res1 !== 32'h1) begin errors++; $display("FAIL umul_res1: got %h expected 1", out_res1); end
    consume();
    run_op(2'd1, 1'b1, 32'hFFFF_FFFD, 32'h4, lat, rs);
    checks++; if ({out_res1, out_res0} !== 64'hFFFF_FFFF_FFFF_FFF4) begin errors++; $display("FAIL smul_neg3x4: got %h%h expected fffffffffffffff4", out_res1, out_res0); end
    consume();
    run_op(2'd1, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, lat, rs);
    checks++; if ({out_res1, out_res0} !== 64'd12) begin errors++; $display("FAIL smul_neg3xneg4: got %h%h expected 12", out_res1, out_res0); end
    consume();
    run_op(2'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat, rs);
    checks++; if ({out_res1, out_res0} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL umul_2p31sq: got %h%h expected 4000000000000000", out_res1, out_res0); end
    consume();
  endtask

  task automatic test_div();
    int lat; logic rs;
    run_op(2'd2, 1'b1, 32'hFFFF_FFF9, 32'h2, lat, rs);
    checks++; if (lat !== 33) begin errors++; $display("FAIL sdiv_latency: got %0d expected 33", lat); end
    checks++; if (out_res0 !== 32'hFFFF_FFFD) begin errors++; $display("FAIL sdiv_m7_q: got %h expected fffffffd", out_res0); end
    checks++; if (out_res1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_m7_r: got %h expected ffffffff", out_res1); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL sdiv_in_ready_busy: got %b expected 0", rs); end
    consume();
    run_op(2'd2, 1'b0, 32'd100, 32'd7, lat, rs);
    checks++; if (out_res0 !== 32'd14) begin errors++; $display("FAIL udiv_q: got %0d expected 14", out_res0); end
    checks++; if (out_res1 !== 32'd2) begin errors++; $display("FAIL udiv_r: got %0d expected 2", out_res1); end
    consume();
    run_op(2'd2, 1'b1, 32'd7, 32'hFFFF_FFFE, lat, rs);
    checks++; if (out_res0 !== 32'hFFFF_FFFD || out_res1 !== 32'd1) begin errors++; $display("FAIL sdiv_7_m2: got q=%h r=%h expected fffffffd/1", out_res0, out_res1); end
    consume();
    run_op(2'd2, 1'b1, 32'hFFFF_FFF8, 32'd2, lat, rs);
    checks++; if (out_res0 !== 32'hFFFF_FFFC || out_res1 !== 32'd0) begin errors++; $display("FAIL sdiv_m8_2: got q=%h r=%h expected fffffffc/0", out_res0, out_res1); end
    consume();
  endtask

  task automatic test_special_div();
    int lat; logic rs;
    run_op(2'd2, 1'b0, 32'd100, 32'd0, lat, rs);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div0_latency: got %0d expected 33", lat); end
    checks++; if (out_res0 !== 32'hFFFF_FFFF || out_res1 !== 32'd100) begin errors++; $display("FAIL div0: got q=%h r=%h expected ffffffff/64", out_res0, out_res1); end
    consume();
    run_op(2'd2, 1'b1, 32'hFFFF_FFFB, 32'd0, lat, rs);
    checks++; if (out_res0 !== 32'hFFFF_FFFF || out_res1 !== 32'hFFFF_FFFB) begin errors++; $display("FAIL sdiv0: got q=%h r=%h expected ffffffff/fffffffb", out_res0, out_res1); end
    consume();
    run_op(2'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, rs);
    checks++; if (lat !== 33) begin errors++; $display("FAIL ovf_latency: got %0d expected 33", lat); end
    checks++; if (out_res0 !== 32'h8000_0000 || out_res1 !== 32'd0) begin errors++; $display("FAIL ovf: got q=%h r=%h expected 80000000/0", out_res0, out_res1); end
    consume();
  endtask

  task automatic test_nop();
    logic [31:0] keep0;
    keep0 = out_res0;
    in_valid = 1'b1; in_src0 = 32'd9; in_src1 = 32'd9; in_sign = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_op = (i < 2) ? 2'd0 : 2'd3;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res0 !== keep0) begin
        errors++; $display("FAIL nop_ignored: got ready=%b valid=%b res0=%h expected 1/0/%h", in_ready, out_valid, out_res0, keep0);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat; logic rs;
    run_op(2'd1, 1'b0, 32'd3, 32'd4, lat, rs);
    in_valid = 1'b1; in_op = 2'd1; in_sign = 1'b0; in_src0 = 32'd5; in_src1 = 32'd6;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_res0 !== 32'd12 || out_res1 !== 32'd0) begin
        errors++; $display("FAIL bp_hold: got valid=%b ready=%b res=%h/%h expected 1/0/0000000c/0", out_valid, in_ready, out_res0, out_res1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", in_ready, out_valid); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got ready=%b expected 0", in_ready); end
    in_valid = 1'b0; in_src0 = 32'd0; in_src1 = 32'd0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    checks++; if (lat !== 5 || out_res0 !== 32'd30 || out_res1 !== 32'd0) begin
      errors++; $display("FAIL b2b_mul: got lat=%0d res=%h/%h expected 5/0000001e/0", lat, out_res0, out_res1);
    end
    consume();
  endtask

  task automatic test_reset_mid_div();
    int lat; logic rs;
    in_src0 = 32'd100; in_src1 = 32'd7; in_op = 2'd2; in_sign = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    checks++; if (out_res0 !== 32'd0 || out_res1 !== 32'd0) begin errors++; $display("FAIL rst_mid_res: got %h/%h expected 0/0", out_res0, out_res1); end
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(2'd1, 1'b0, 32'd3, 32'd4, lat, rs);
    checks++; if (lat !== 5 || out_res0 !== 32'd12 || out_res1 !== 32'd0) begin
      errors++; $display("FAIL rst_then_mul: got lat=%0d res=%h/%h expected 5/0000000c/0", lat, out_res0, out_res1);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special_div();
    test_nop();
    test_back_to_back();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
